cla_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 17 +
 rtl/cla_group4.sv | 40 ++++
 rtl/cla_adder.sv | 103 ++++++++++
 tb/tb_cla_adder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
// Group size is fixed at four bits; WIDTH must be a multiple of it.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  // Number of 4-bit lookahead groups for a given operand width.
  function automatic int cla_groups(input int width);
    return width / CLA_GROUP;
  endfunction

  // True when the width splits into whole groups within 4..64 bits.
  function automatic bit cla_width_ok(input int width);
    return (width % CLA_GROUP == 0) && (width >= 4) && (width <= 64);
  endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group: closed-form internal carries,
// group propagate/generate for the second lookahead level.
module cla_group4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] s,
  output logic                 pg,
  output logic                 gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  // Bit propagate/generate, expanded carries, sum and group terms.
  always_comb begin
    p = a ^ b;
    g = a & b;
    c[0] = cin;
    c[1] = g[0]
         | (p[0] & cin);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    s  = p ^ c;
    pg = &p;
    gg = g[3]
       | (p[3] & g[2])
       | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/cla_adder.sv
// Registered WIDTH-bit two-level carry-lookahead adder, 1-cycle latency.
// Define CLA_OVF_FLAG_EN to add the registered signed-overflow output Ovf.
module cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic [WIDTH-1:0] S,
`ifdef CLA_OVF_FLAG_EN
  output logic             Co,
  output logic             Ovf
`else
  output logic             Co
`endif
);

  localparam int NG = cla_groups(WIDTH);

  if (!cla_width_ok(WIDTH)) begin : g_bad_width
    $error("cla_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  logic [NG-1:0]    pg;
  logic [NG-1:0]    gg;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .a   (A[CLA_GROUP*k +: CLA_GROUP]),
      .b   (B[CLA_GROUP*k +: CLA_GROUP]),
      .cin (gc[k]),
      .s   (sum[CLA_GROUP*k +: CLA_GROUP]),
      .pg  (pg[k]),
      .gg  (gg[k])
    );
  end

  // Second level: each group carry-in is a flat sum of products of
  // Ci and the lower groups' PG/GG, so no carry ripples between groups.
  always_comb begin
    logic acc;
    logic term;
    gc    = '0;
    gc[0] = Ci;
    for (int k = 1; k <= NG; k++) begin
      acc = Ci;
      for (int m = 0; m < k; m++) acc = acc & pg[m];
      for (int j = 0; j < k; j++) begin
        term = gg[j];
        for (int m = j + 1; m < k; m++) term = term & pg[m];
        acc = acc | term;
      end
      gc[k] = acc;
    end
  end

  logic [WIDTH-1:0] s_d, s_q;
  logic             co_d, co_q;

  // Next-state values of the output registers.
  always_comb begin
    s_d  = sum;
    co_d = gc[NG];
  end

  // Output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign S  = s_q;
  assign Co = co_q;

`ifdef CLA_OVF_FLAG_EN
  logic ovf_d, ovf_q;

  // Carry into the MSB is recovered from s = p ^ c at the top bit.
  always_comb begin
    ovf_d = (sum[WIDTH-1] ^ A[WIDTH-1] ^ B[WIDTH-1]) ^ gc[NG];
  end

  // Overflow flag register, same timing as S/Co.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_adder.sv
// Randomised self-checking bench for cla_adder at WIDTH 16 and 32.
// Reference: plain integer addition, one cycle delayed.
module tb_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ci;
  logic [15:0] a16, b16, s16;
  logic [31:0] a32, b32, s32;
  logic        co16, co32;
`ifdef CLA_OVF_FLAG_EN
  logic        ovf16, ovf32;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_adder #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .A   (a16),
    .B   (b16),
    .Ci  (ci),
    .S   (s16),
`ifdef CLA_OVF_FLAG_EN
    .Co  (co16),
    .Ovf (ovf16)
`else
    .Co  (co16)
`endif
  );

  cla_adder #(.WIDTH(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .A   (a32),
    .B   (b32),
    .Ci  (ci),
    .S   (s32),
`ifdef CLA_OVF_FLAG_EN
    .Co  (co32),
    .Ovf (ovf32)
`else
    .Co  (co32)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] ref16(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  function automatic logic [32:0] ref32(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic c);
    return 33'(a) + 33'(b) + 33'(c);
  endfunction

  function automatic logic sovf(input longint sa,
                                input longint sb,
                                input logic c,
                                input int w);
    longint sum;
    longint lim;
    sum = sa + sb + longint'(c);
    lim = longint'(1) << (w - 1);
    return (sum >= lim) || (sum < -lim);
  endfunction

  // One directed cycle: 16-bit result against the given constants,
  // 32-bit instance (driven with {a,b}/{b,a}) against the model.
  task automatic step(input string tag,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic c,
                      input logic r,
                      input logic [15:0] es,
                      input logic eco);
    logic [32:0] e32;
    logic        eo16, eo32;
    @(negedge clk);
    rst = r;
    a16 = a;
    b16 = b;
    a32 = {a, b};
    b32 = {b, a};
    ci  = c;
    e32 = r ? 33'd0 : ref32(a32, b32, c);
    eo16 = r ? 1'b0 : sovf(longint'($signed(a)),
                           longint'($signed(b)), c, 16);
    eo32 = r ? 1'b0 : sovf(longint'($signed(a32)),
                           longint'($signed(b32)), c, 32);
    @(posedge clk);
    #1;
    chk({tag, ".s16"}, 64'(s16), 64'(es));
    chk({tag, ".co16"}, 64'(co16), 64'(eco));
    chk({tag, ".s32"}, 64'(s32), 64'(e32[31:0]));
    chk({tag, ".co32"}, 64'(co32), 64'(e32[32]));
`ifdef CLA_OVF_FLAG_EN
    chk({tag, ".ovf16"}, 64'(ovf16), 64'(eo16));
    chk({tag, ".ovf32"}, 64'(ovf32), 64'(eo32));
`else
    if (eo16 & eo32 & 1'b0) $display("unreachable");
`endif
  endtask

  logic [16:0] q16;
  logic [32:0] q32;
  logic        qo16, qo32;

  initial begin
    rst = 1'b1;
    ci  = 1'b0;
    a16 = '0;
    b16 = '0;
    a32 = '0;
    b32 = '0;

    step("rst0", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h0, 1'b0);
    step("rst1", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h0, 1'b0);
    step("rel",  16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0);

    step("b10", 16'd10, 16'd0,  1'b0, 1'b0, 16'd10, 1'b0);
    step("b20", 16'd20, 16'd0,  1'b0, 1'b0, 16'd20, 1'b0);
    step("b30", 16'd20, 16'd10, 1'b0, 1'b0, 16'd30, 1'b0);
    step("b40", 16'd20, 16'd20, 1'b0, 1'b0, 16'd40, 1'b0);

    step("ff", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1);
    step("7f", 16'h7FFF, 16'hFFFF, 1'b0, 1'b0, 16'h7FFE, 1'b1);
    step("bf", 16'hBFFF, 16'hFFFF, 1'b0, 1'b0, 16'hBFFE, 1'b1);

    step("cin_all", 16'hFFFF, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    step("cin_grp", 16'h000F, 16'h0, 1'b1, 1'b0, 16'h0010, 1'b0);
    step("zero",    16'h0,    16'h0, 1'b0, 1'b0, 16'h0, 1'b0);

    step("ov_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
`ifdef CLA_OVF_FLAG_EN
    chk("ov_pos.flag", 64'(ovf16), 64'd1);
`endif
    step("ov_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0, 1'b1);
`ifdef CLA_OVF_FLAG_EN
    chk("ov_neg.flag", 64'(ovf16), 64'd1);
`endif
    step("mid_rst", 16'h8000, 16'h8000, 1'b1, 1'b1, 16'h0, 1'b0);
`ifdef CLA_OVF_FLAG_EN
    chk("mid_rst.flag", 64'(ovf16), 64'd0);
`endif
    step("post_rst", 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);

    @(negedge clk);
    a32 = 32'hFFFF_FFFF;
    b32 = 32'h1;
    ci  = 1'b0;
    @(posedge clk);
    #1;
    chk("w32_wrap.s", 64'(s32), 64'd0);
    chk("w32_wrap.co", 64'(co32), 64'd1);

    // Back-to-back random vectors: check last cycle's result, then drive.
    for (int i = 0; i <= 10000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("rnd.s16", 64'(s16), 64'(q16[15:0]));
        chk("rnd.co16", 64'(co16), 64'(q16[16]));
        chk("rnd.s32", 64'(s32), 64'(q32[31:0]));
        chk("rnd.co32", 64'(co32), 64'(q32[32]));
`ifdef CLA_OVF_FLAG_EN
        chk("rnd.ovf16", 64'(ovf16), 64'(qo16));
        chk("rnd.ovf32", 64'(ovf32), 64'(qo32));
`endif
      end
      if (i < 10000) begin
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        a32 = $urandom;
        b32 = $urandom;
        ci  = 1'($urandom_range(0, 1));
        if (i % 7 == 0) a32 = 32'hFFFF_FFFF ^ b32;
        if (i % 11 == 0) a16 = 16'hFFFF ^ b16;
        q16  = ref16(a16, b16, ci);
        q32  = ref32(a32, b32, ci);
        qo16 = sovf(longint'($signed(a16)),
                    longint'($signed(b16)), ci, 16);
        qo32 = sovf(longint'($signed(a32)),
                    longint'($signed(b32)), ci, 32);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
